dcache_ctrl: RTL

Direct-mapped, write-back, write-allocate data-cache controller between the MEM stage and the 256-bit off-chip data memory. It owns the tag/valid/dirty state and the line storage, and sequences write-back and refill on a miss. It drives the single memory-stall signal that freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB while a miss is serviced.

---
 rtl/dcache_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data-cache controller with 256-bit line refill/write-back.
// Define DCACHE_STATS_EN to add hit_cnt_o / miss_cnt_o access counters.
module dcache_ctrl #(
    parameter int LINES = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         p1_req_i,
    input  logic         p1_write_i,
    input  logic [31:0]  p1_addr_i,
    input  logic [31:0]  p1_data_i,
    output logic [31:0]  p1_data_o,
    output logic         p1_stall_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]  hit_cnt_o,
    output logic [31:0]  miss_cnt_o
`endif
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 27 - IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE,
        REFILL
    } state_e;

    state_e               state_q, state_d;
    logic [LINES-1:0]     valid_q, valid_d;
    logic [LINES-1:0]     dirty_q, dirty_d;
    logic [255:0]         fill_q, fill_d;
    logic [TAG_W-1:0]     tag_mem [LINES];
    logic [255:0]         line_mem [LINES];

    logic [IDX_W-1:0]     idx;
    logic [TAG_W-1:0]     req_tag;
    logic [2:0]           word_sel;
    logic [7:0]           word_lsb;
    logic [255:0]         cur_line;
    logic [TAG_W-1:0]     cur_tag;
    logic                 tag_hit;
    logic                 line_we;
    logic                 tag_we;
    logic [255:0]         line_wdata;
    logic                 unused_addr_bits;

    assign idx              = p1_addr_i[5 +: IDX_W];
    assign req_tag          = p1_addr_i[31 -: TAG_W];
    assign word_sel         = p1_addr_i[4:2];
    assign word_lsb         = {word_sel, 5'b0};
    assign cur_line         = line_mem[idx];
    assign cur_tag          = tag_mem[idx];
    assign tag_hit          = valid_q[idx] && (cur_tag == req_tag);
    assign unused_addr_bits = ^p1_addr_i[1:0];

    // Loads return zero unless the addressed line is present, which also covers the post-reset case.
    assign p1_data_o  = tag_hit ? cur_line[word_lsb +: 32] : 32'h0;
    assign p1_stall_o = p1_req_i && ((state_q != IDLE) || !tag_hit);

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        fill_d       = fill_q;
        line_we      = 1'b0;
        tag_we       = 1'b0;
        line_wdata   = cur_line;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = 32'h0;
        mem_data_o   = 256'h0;

        unique case (state_q)
            IDLE: begin
                if (p1_req_i) begin
                    if (tag_hit) begin
                        if (p1_write_i) begin
                            line_wdata[word_lsb +: 32] = p1_data_i;
                            line_we                    = 1'b1;
                            dirty_d[idx]               = 1'b1;
                        end
                    end else if (valid_q[idx] && dirty_q[idx]) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {cur_tag, idx, 5'b0};
                mem_data_o   = cur_line;
                if (mem_ack_i) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {p1_addr_i[31:5], 5'b0};
                if (mem_ack_i) begin
                    fill_d  = mem_data_i;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                // Store data is not merged here; the request replays in IDLE as a hit.
                line_we      = 1'b1;
                line_wdata   = fill_q;
                tag_we       = 1'b1;
                valid_d[idx] = 1'b1;
                dirty_d[idx] = 1'b0;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            fill_q  <= fill_d;
        end
    end

    // Line and tag storage carry no reset; the valid bits alone decide whether they are used.
    always_ff @(posedge clk_i) begin
        if (rst_i && line_we) begin
            line_mem[idx] <= line_wdata;
        end
        if (rst_i && tag_we) begin
            tag_mem[idx] <= req_tag;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if ((state_q == IDLE) && p1_req_i) begin
            if (tag_hit) begin
                hit_cnt_d = hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
